// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: WB stage vs. buffered long-latency results.
// Holds a pending scoreboard for LLU destinations that drives decode stall.
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WbValid,
  input  logic [4:0]  WbRegNum,
  input  logic [31:0] WbData,
  output logic        WbHold,
  input  logic        LluIssue,
  input  logic [4:0]  LluIssueRegNum,
  input  logic        LluValid,
  input  logic [4:0]  LluRegNum,
  input  logic [31:0] LluData,
  output logic        LluReady,
  input  logic [4:0]  ReadRegNum1,
  input  logic [4:0]  ReadRegNum2,
  output logic        Stall,
  output logic        RegWrite,
  output logic [4:0]  WriteRegNum,
  output logic [31:0] WriteRegData,
  output logic [3:0]  FifoCount
);

  localparam int         AW    = $clog2(DEPTH);
  localparam logic [3:0] FULL  = 4'(DEPTH);
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [4:0]    fifoNum  [DEPTH];
  logic [31:0]   fifoData [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [3:0]    count;
  logic [2:0]    starveCnt;
  logic [31:0]   pending;
  logic [31:0]   pendingNext;

  logic          empty;
  logic          push;
  logic          pop;
  logic          selFifo;
  logic          selWb;
  logic          selAny;
  logic [4:0]    selNum;
  logic [31:0]   selData;
  logic [4:0]    headNum;
  logic [31:0]   headData;

  assign empty     = (count == 4'd0);
  assign LluReady  = (count != FULL);
  assign FifoCount = count;
  assign WbHold    = (starveCnt == LIMIT);
  assign headNum   = fifoNum[rdPtr];
  assign headData  = fifoData[rdPtr];

  assign selFifo = !empty && (WbHold || !WbValid);
  assign selWb   = !WbHold && WbValid;
  assign pop     = selFifo;
  assign push    = LluValid && LluReady;

  assign Stall = pending[ReadRegNum1] | pending[ReadRegNum2];

  // Pick the write source; a held WB stage yields to the FIFO head.
  always_comb begin
    selAny  = 1'b0;
    selNum  = '0;
    selData = '0;
    unique case (1'b1)
      selFifo: begin
        selAny  = 1'b1;
        selNum  = headNum;
        selData = headData;
      end
      selWb: begin
        selAny  = 1'b1;
        selNum  = WbRegNum;
        selData = WbData;
      end
      default: ;
    endcase
  end

  // Scoreboard update: pop clears, issue sets, and set wins a tie.
  always_comb begin
    pendingNext = pending;
    if (pop)
      pendingNext[headNum] = 1'b0;
    if (LluIssue && LluIssueRegNum != 5'd0)
      pendingNext[LluIssueRegNum] = 1'b1;
    pendingNext[0] = 1'b0;
  end

  // Registered write port; register 0 is consumed without a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite     <= 1'b0;
      WriteRegNum  <= '0;
      WriteRegData <= '0;
    end else begin
      RegWrite <= selAny && (selNum != 5'd0);
      if (selAny) begin
        WriteRegNum  <= selNum;
        WriteRegData <= selData;
      end
    end
  end

  // LLU result FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifoNum[i]  <= '0;
        fifoData[i] <= '0;
      end
    end else begin
      if (push) begin
        fifoNum[wrPtr]  <= LluRegNum;
        fifoData[wrPtr] <= LluData;
        wrPtr           <= wrPtr + 1'b1;
      end
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      count <= count + 4'(push) - 4'(pop);
    end
  end

  // Starvation counter: counts cycles the head waits for the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starveCnt <= '0;
    else if (pop || empty)
      starveCnt <= '0;
    else
      starveCnt <= starveCnt + 3'd1;
  end

  // Pending-destination scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pendingNext;
  end

endmodule
